// File: rtl/seq_mag_comparator_if.sv
// Operand/result bundle for the sequential magnitude comparator.
// The master drives the request (start, a, b, signed_mode) and observes the
// status and result flags; the comparator sits on the slave side.
interface seq_mag_comparator_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             signed_mode;
    logic             busy;
    logic             done;
    logic             eq;
    logic             gt;
    logic             lt;

    modport master (
        output start, a, b, signed_mode,
        input  busy, done, eq, gt, lt
    );

    modport slave (
        input  start, a, b, signed_mode,
        output busy, done, eq, gt, lt
    );
endinterface

// File: rtl/seq_mag_comparator.sv
// Sequential magnitude comparator: walks the latched operands one CHUNK at a
// time from the most significant chunk down, stopping at the first chunk that
// differs. In signed mode only the top chunk needs special handling: if the
// sign bits differ the non-negative operand wins, otherwise plain unsigned
// ordering of the chunks gives the two's-complement answer.
module seq_mag_comparator #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seq_mag_comparator_if.slave  bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             sm;
    } req_t;

    state_t           state, state_d;
    req_t             req_q;
    logic [IDX_W-1:0] idx;
    logic             eq_q, gt_q, lt_q;

    logic             load, dec, upd;
    logic [WIDTH-1:0] a_sh, b_sh;
    logic [CHUNK-1:0] a_c, b_c;
    logic             chunk_eq, a_gt;

    // Select the current chunk and decide its ordering.
    always_comb begin
        a_sh     = req_q.a >> (int'(idx) * CHUNK);
        b_sh     = req_q.b >> (int'(idx) * CHUNK);
        a_c      = a_sh[CHUNK-1:0];
        b_c      = b_sh[CHUNK-1:0];
        chunk_eq = (a_c == b_c);
        if (req_q.sm && (idx == IDX_TOP) && (a_c[CHUNK-1] != b_c[CHUNK-1]))
            a_gt = ~a_c[CHUNK-1];
        else
            a_gt = (a_c > b_c);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state;
        load    = 1'b0;
        dec     = 1'b0;
        upd     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    load    = 1'b1;
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (!chunk_eq || idx == '0) begin
                    upd     = 1'b1;
                    state_d = DONE;
                end else begin
                    dec = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Operand latch, chunk index and result flags; flags only move on
    // COMPARE->DONE so they hold between operations.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            req_q <= '0;
            idx   <= '0;
            eq_q  <= 1'b0;
            gt_q  <= 1'b0;
            lt_q  <= 1'b0;
        end else begin
            if (load) begin
                req_q <= '{a: bus.a, b: bus.b, sm: bus.signed_mode};
                idx   <= IDX_TOP;
            end else if (dec) begin
                idx <= idx - 1'b1;
            end
            if (upd) begin
                eq_q <= chunk_eq;
                gt_q <= ~chunk_eq & a_gt;
                lt_q <= ~chunk_eq & ~a_gt;
            end
        end
    end

    assign bus.busy = (state == COMPARE);
    assign bus.done = (state == DONE);
    assign bus.eq   = eq_q;
    assign bus.gt   = gt_q;
    assign bus.lt   = lt_q;
endmodule

// File: doc/seq_mag_comparator.md
SEQ_MAG_COMPARATOR -- requirements
Module: seq_mag_comparator

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits compared per cycle; WIDTH SHALL be an integer multiple of CHUNK, CHUNK >= 1.
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port start  input  1  request a comparison; accepted only in IDLE.
REQ-006 SHALL have port a  input  WIDTH  operand A, sampled on accepted start.
REQ-007 SHALL have port b  input  WIDTH  operand B, sampled on accepted start.
REQ-008 SHALL have port signed_mode  input  1  1 = two's-complement compare, 0 = unsigned; sampled on accepted start.
REQ-009 SHALL have port busy  output  1  high while in COMPARE.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-011 SHALL have port eq  output  1  A == B.
REQ-012 SHALL have port gt  output  1  A > B.
REQ-013 SHALL have port lt  output  1  A < B.

Function
REQ-014 SHALL implement states IDLE, COMPARE, DONE; N = WIDTH/CHUNK chunks, chunk N-1 = most significant.
REQ-015 IDLE: start=1 SHALL latch a, b, signed_mode into internal registers, load chunk index N-1, go to COMPARE; start=0 stays IDLE.
REQ-016 start SHALL be ignored in COMPARE and DONE; latched operands SHALL NOT change until the next accepted start.
REQ-017 COMPARE: each cycle SHALL compare exactly one chunk (current index) of latched A and B, MSB chunk first.
REQ-018 Chunk unequal: SHALL set gt/lt from that chunk per REQ-020, clear eq, go to DONE (early termination).
REQ-019 Chunk equal and index > 0: SHALL decrement index, stay COMPARE; equal and index == 0: SHALL set eq=1, gt=lt=0, go to DONE.
REQ-020 Chunk ordering: unsigned chunk magnitude, except MSB chunk with signed_mode=1 and differing MSBs, where the operand with MSB=0 SHALL be greater.
REQ-021 DONE: done SHALL be 1 for exactly this one cycle, then unconditionally go to IDLE.
REQ-022 eq/gt/lt SHALL update only on the COMPARE->DONE transition and hold until the next such transition; exactly one of them SHALL be 1 after the first completed compare.
REQ-023 busy SHALL be 1 exactly in COMPARE; busy and done SHALL never both be 1.
REQ-024 Latency: start-accepted edge to done=1 SHALL be k+1 cycles, k = 1 + number of equal chunks above the first differing chunk (k = N when A == B); maximum N+1.
REQ-025 Back-to-back: start held high SHALL be accepted in the IDLE cycle following DONE, giving one idle cycle between operations.
REQ-026 CHUNK == WIDTH SHALL be supported (single-cycle COMPARE, latency 2).

Reset
REQ-027 rst_n=0 at a rising clk edge SHALL force IDLE, busy=0, done=0, eq=0, gt=0, lt=0, chunk index=0, operand registers=0.
REQ-028 Reset SHALL take priority over start and over any state, including mid-COMPARE; the aborted compare SHALL produce no done pulse.
REQ-029 No output SHALL change asynchronously to clk on rst_n assertion.

Verification (WIDTH=16, CHUNK=4)
REQ-030 Unsigned equal: a=16'h1234, b=16'h1234, signed_mode=0, start 1 cycle -> busy 4 cycles, done on 5th cycle, eq=1, gt=lt=0.
REQ-031 Early exit: a=16'h8000, b=16'h7FFF, signed_mode=0 -> busy 1 cycle, done cycle 2, gt=1; same operands signed_mode=1 -> lt=1, done cycle 2.
REQ-032 Low-chunk difference: a=16'h00A1, b=16'h00A2, signed_mode=1 -> busy 4 cycles, lt=1; start pulsed while busy with a=b=0 -> ignored, result unchanged.
REQ-033 Mid-operation reset: start a=b=16'hFFFF, rst_n=0 on 2nd COMPARE cycle -> next cycle busy=0, eq=gt=lt=0, no done pulse; subsequent start compares fresh operands correctly.
REQ-034 Back-to-back: start held high, alternating a>b and a<b operand pairs -> done pulses with correct gt/lt each time, one IDLE cycle between DONE and next COMPARE, results held between pulses.
REQ-035 Parameter sweep: CHUNK=16 and CHUNK=1 with a=16'hFFFE, b=16'hFFFF unsigned -> lt=1 with latency 2 and 17 cycles respectively.
